dm_port_arbiter: RTL
====================

Name: dm_port_arbiter

Overview:
- Arbitrates the single-port data memory between two requesters: the SPI slave FSM (port A) and a local host/debug port (port H).
- Sits between both requesters and the data memory; owns dm_addr, dm_wdata and dm_we.
- Serialises accesses, generates one-cycle grant and read-valid strobes, and guarantees exactly one memory write per granted write.

Parameters:
ADDR_W, 7, memory address width
DATA_W, 8, memory data width

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high reset
chipSelect  in  1  SPI chip select, active low; low = SPI transaction in progress
a_req  in  1  SPI port access request
a_we  in  1  SPI port: 1 = write, 0 = read
a_addr  in  ADDR_W  SPI port address
a_wdata  in  DATA_W  SPI port write data
a_gnt  out  1  SPI port grant pulse
a_rvalid  out  1  SPI port read data valid pulse
a_rdata  out  DATA_W  SPI port read data, held until the next A read completes
h_req  in  1  host port access request
h_we  in  1  host port: 1 = write, 0 = read
h_addr  in  ADDR_W  host address
h_wdata  in  DATA_W  host write data
h_gnt  out  1  host grant pulse
h_rvalid  out  1  host read data valid pulse
h_rdata  out  DATA_W  host read data, held until the next H read completes
dm_addr  out  ADDR_W  memory address
dm_wdata  out  DATA_W  memory write data
dm_we  out  1  memory write enable
dm_rdata  in  DATA_W  memory read data; synchronous, valid one cycle after the address

Behaviour:
- FSM states: IDLE, ACC_A, ACC_H, RESP_A, RESP_H. All outputs are registered.
- Reset (synchronous; overrides all other inputs):
  - state = IDLE.
  - a_gnt, h_gnt, a_rvalid, h_rvalid, dm_we = 0.
  - dm_addr, dm_wdata, a_rdata, h_rdata = 0.
  - last_grant = H.
- IDLE: the winner is chosen from the requests sampled at the posedge.
  - Winner A: go to ACC_A. Winner H: go to ACC_H. No request: stay in IDLE.
- ACC_x (one cycle):
  - gnt_x = 1; dm_addr = x_addr; dm_wdata = x_wdata; dm_we = x_we.
  - Write: next state IDLE.
  - Read: next state RESP_x.
- RESP_x (one cycle):
  - x_rdata <= dm_rdata; x_rvalid = 1 during the following cycle; dm_we = 0.
  - Next state IDLE.
- Latency from request seen in IDLE:
  - Grant: 1 cycle.
  - Read data valid: 3 cycles.
  - Write occupies 2 cycles per access; read occupies 3.
- Requester contract:
  - Hold req, we, addr and wdata stable until the gnt pulse.
  - Deassert req, or present the next request, in the cycle after gnt.
  - Dropping req before grant is legal; the arbiter re-evaluates every IDLE cycle, and no access occurs.
- Priority (base build): fixed priority.
  - If chipSelect = 0: A beats H.
  - If chipSelect = 1: a_req is ignored entirely; only H can win.
- dm_we is asserted only in ACC_x with x_we = 1, for exactly one cycle per granted write.
- Back-to-back writes to the same address are not merged.
- chipSelect rising during ACC_A or RESP_A: the access completes normally, including rvalid.
- h_req present while A is in ACC_A or RESP_A: H waits; no state is skipped.
- Reset mid-access:
  - The in-flight access is abandoned and no rvalid is issued.
  - If reset coincides with ACC_x of a write, dm_we is forced to 0 that cycle.
- Never more than one of a_gnt and h_gnt is high; never more than one of a_rvalid and h_rvalid is high.
- last_grant updates on every ACC_x entry.

Optional Feature:
- Macro: DM_ARB_ROUND_ROBIN_EN.
- Defined: when both requesters are eligible in IDLE, the port that did not receive the previous grant (per last_grant) wins. This bounds host wait to one SPI access.
- Undefined: fixed priority as described in Behaviour; last_grant is still maintained but unused.

Test Plan:
- Host write then read: reset, chipSelect = 1, host writes 0x5A to address 0x12, then reads 0x12 -> h_gnt 1 cycle after each request; dm_we = 1 for exactly 1 cycle with dm_addr = 0x12; h_rvalid 3 cycles after the read request with h_rdata = 0x5A.
- chipSelect gating: chipSelect = 1, a_req = 1 held for 10 cycles -> no a_gnt, dm_we stays 0. chipSelect = 0 -> a_gnt 1 cycle later.
- Contention, base build: chipSelect = 0, a_req and h_req both asserted, both reads, both held after grant -> A granted on every access; h_gnt stays 0 until a_req drops.
- Contention with DM_ARB_ROUND_ROBIN_EN defined, same stimulus -> grants alternate A, H, A, H; after 4 accesses each port has exactly 2 rvalid pulses.
- Reset mid-read: issue a host read to 0x03, assert reset in the RESP_H cycle -> no h_rvalid; h_rdata = 0; state IDLE; the next access completes normally.
- chipSelect rise mid-access: A read of 0x7F (preloaded with 0xC3) with chipSelect rising in ACC_A -> a_rvalid still pulses with a_rdata = 0xC3.

Source files
------------

// File: rtl/dm_port_arbiter.sv
// Two-port arbiter (SPI port A, host port H) for a single-port synchronous data memory.
// Optional macro DM_ARB_ROUND_ROBIN_EN swaps fixed A-over-H priority for alternating priority.
module dm_port_arbiter #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              chipSelect,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              h_req,
  input  logic              h_we,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [DATA_W-1:0] h_wdata,
  output logic              h_gnt,
  output logic              h_rvalid,
  output logic [DATA_W-1:0] h_rdata,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_wdata,
  output logic              dm_we,
  input  logic [DATA_W-1:0] dm_rdata
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACC_A  = 3'd1,
    S_ACC_H  = 3'd2,
    S_RESP_A = 3'd3,
    S_RESP_H = 3'd4
  } state_t;

  typedef enum logic {
    LG_A = 1'b0,
    LG_H = 1'b1
  } grant_t;

  state_t              r_state, w_state_nxt;
  grant_t              r_last_grant, w_last_grant_nxt;
  logic                r_a_gnt, w_a_gnt_nxt;
  logic                r_h_gnt, w_h_gnt_nxt;
  logic                r_a_rvalid, w_a_rvalid_nxt;
  logic                r_h_rvalid, w_h_rvalid_nxt;
  logic [DATA_W-1:0]   r_a_rdata, w_a_rdata_nxt;
  logic [DATA_W-1:0]   r_h_rdata, w_h_rdata_nxt;
  logic [ADDR_W-1:0]   r_dm_addr, w_dm_addr_nxt;
  logic [DATA_W-1:0]   r_dm_wdata, w_dm_wdata_nxt;
  logic                r_dm_we, w_dm_we_nxt;

  logic w_a_elig;
  logic w_h_elig;
  logic w_pick_a;
  logic w_pick_h;

  // SPI requests only count while its transaction is framed by chipSelect low.
  assign w_a_elig = a_req & ~chipSelect;
  assign w_h_elig = h_req;

`ifdef DM_ARB_ROUND_ROBIN_EN
  assign w_pick_a = w_a_elig & (~w_h_elig | (r_last_grant == LG_H));
`else
  assign w_pick_a = w_a_elig;
`endif
  assign w_pick_h = w_h_elig & ~w_pick_a;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latch).
    w_state_nxt      = r_state;
    w_last_grant_nxt = r_last_grant;
    w_a_gnt_nxt      = 1'b0;
    w_h_gnt_nxt      = 1'b0;
    w_a_rvalid_nxt   = 1'b0;
    w_h_rvalid_nxt   = 1'b0;
    w_a_rdata_nxt    = r_a_rdata;
    w_h_rdata_nxt    = r_h_rdata;
    w_dm_addr_nxt    = r_dm_addr;
    w_dm_wdata_nxt   = r_dm_wdata;
    w_dm_we_nxt      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (w_pick_a) begin
          w_state_nxt      = S_ACC_A;
          w_last_grant_nxt = LG_A;
          w_a_gnt_nxt      = 1'b1;
          w_dm_addr_nxt    = a_addr;
          w_dm_wdata_nxt   = a_wdata;
          w_dm_we_nxt      = a_we;
        end else if (w_pick_h) begin
          w_state_nxt      = S_ACC_H;
          w_last_grant_nxt = LG_H;
          w_h_gnt_nxt      = 1'b1;
          w_dm_addr_nxt    = h_addr;
          w_dm_wdata_nxt   = h_wdata;
          w_dm_we_nxt      = h_we;
        end
      end
      // The registered write enable tells us whether the access in flight is a write.
      S_ACC_A: w_state_nxt = r_dm_we ? S_IDLE : S_RESP_A;
      S_ACC_H: w_state_nxt = r_dm_we ? S_IDLE : S_RESP_H;
      S_RESP_A: begin
        w_state_nxt    = S_IDLE;
        w_a_rdata_nxt  = dm_rdata;
        w_a_rvalid_nxt = 1'b1;
      end
      S_RESP_H: begin
        w_state_nxt    = S_IDLE;
        w_h_rdata_nxt  = dm_rdata;
        w_h_rvalid_nxt = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments; reset is synchronous and overrides everything.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_last_grant <= LG_H;
      r_a_gnt      <= 1'b0;
      r_h_gnt      <= 1'b0;
      r_a_rvalid   <= 1'b0;
      r_h_rvalid   <= 1'b0;
      r_a_rdata    <= '0;
      r_h_rdata    <= '0;
      r_dm_addr    <= '0;
      r_dm_wdata   <= '0;
      r_dm_we      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_last_grant <= w_last_grant_nxt;
      r_a_gnt      <= w_a_gnt_nxt;
      r_h_gnt      <= w_h_gnt_nxt;
      r_a_rvalid   <= w_a_rvalid_nxt;
      r_h_rvalid   <= w_h_rvalid_nxt;
      r_a_rdata    <= w_a_rdata_nxt;
      r_h_rdata    <= w_h_rdata_nxt;
      r_dm_addr    <= w_dm_addr_nxt;
      r_dm_wdata   <= w_dm_wdata_nxt;
      r_dm_we      <= w_dm_we_nxt;
    end
  end

  assign a_gnt    = r_a_gnt;
  assign h_gnt    = r_h_gnt;
  assign a_rvalid = r_a_rvalid;
  assign h_rvalid = r_h_rvalid;
  assign a_rdata  = r_a_rdata;
  assign h_rdata  = r_h_rdata;
  assign dm_addr  = r_dm_addr;
  assign dm_wdata = r_dm_wdata;
  assign dm_we    = r_dm_we;

endmodule
